// File: rtl/fpga_itrng_pkg.sv
// Shared types and default constants for the FPGA internal-TRNG stimulus source.
package fpga_itrng_pkg;

  typedef enum logic [1:0] {
    ITRNG_FIB    = 2'd0,
    ITRNG_LFSR   = 2'd1,
    ITRNG_STUCK  = 2'd2,
    ITRNG_REPEAT = 2'd3
  } itrng_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EMIT = 2'd2
  } itrng_state_e;

  localparam logic [31:0] ITRNG_LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] ITRNG_LFSR_SEED = 32'hACE1_2468;

endpackage

// File: rtl/fpga_itrng_lfsr.sv
// Free-running Galois LFSR (right shift) with a reseed port; a zero seed
// falls back to SEED so the register can never lock up at all-zeros.
module fpga_itrng_lfsr
  import fpga_itrng_pkg::*;
#(
  parameter int unsigned     W     = 32,
  parameter int unsigned     OUT_W = 4,
  parameter logic [W-1:0]    POLY  = W'(ITRNG_LFSR_POLY),
  parameter logic [W-1:0]    SEED  = W'(ITRNG_LFSR_SEED)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [W-1:0]     seed_i,
  output logic [OUT_W-1:0] data_o
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? SEED : seed_i;
    end else if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ POLY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign data_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/fpga_itrng_gen.sv
// Pseudo-random itrng_data/itrng_valid source for FPGA builds: selectable
// generator, idle-gap divider, burst length, reseed and a saturating sample count.
module fpga_itrng_gen
  import fpga_itrng_pkg::*;
#(
  parameter int unsigned        DATA_W    = 4,
  parameter int unsigned        LFSR_W    = 32,
  parameter logic [LFSR_W-1:0]  LFSR_POLY = LFSR_W'(ITRNG_LFSR_POLY),
  parameter logic [LFSR_W-1:0]  LFSR_SEED = LFSR_W'(ITRNG_LFSR_SEED),
  parameter int unsigned        DIV_W     = 16,
  parameter int unsigned        BURST_W   = 4
) (
  input  logic               core_clk,
  input  logic               cptra_rst,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [DATA_W-1:0]  stuck_val,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed,
  output logic [DATA_W-1:0]  itrng_data,
  output logic               itrng_valid,
  output logic               busy,
  output logic [31:0]        sample_count
);

  // itrng_valid is a one-cycle pulse per sample with no back-pressure:
  // itrng_data is meaningful on that cycle and simply held otherwise.

  itrng_state_e       state_q;
  itrng_mode_e        mode_q;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   wait_cnt_q;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] burst_cnt_q;
  logic [DATA_W-1:0]  last_q;
  logic [DATA_W-1:0]  data_q;
  logic               valid_q;
  logic [31:0]        count_q;

  logic [DATA_W-1:0]  fib_a_q, fib_a_d;
  logic [DATA_W-1:0]  fib_b_q, fib_b_d;
  logic [DATA_W-1:0]  lfsr_data;
  logic [DATA_W-1:0]  sample;
  logic [DIV_W-1:0]   div_eff;
  logic [BURST_W-1:0] burst_eff;

  fpga_itrng_lfsr #(
    .W     (LFSR_W),
    .OUT_W (DATA_W),
    .POLY  (LFSR_POLY),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk_i  (core_clk),
    .rst_i  (cptra_rst),
    .load_i (seed_load),
    .seed_i (seed),
    .data_o (lfsr_data)
  );

  always_comb begin
    if (seed_load) begin
      fib_a_d = seed[DATA_W-1:0] | DATA_W'(1);
      fib_b_d = DATA_W'(1);
    end else begin
      fib_a_d = fib_b_q;
      fib_b_d = fib_a_q + fib_b_q;
    end
  end

  always_ff @(posedge core_clk) begin
    if (cptra_rst) begin
      fib_a_q <= DATA_W'(1);
      fib_b_q <= DATA_W'(1);
    end else begin
      fib_a_q <= fib_a_d;
      fib_b_q <= fib_b_d;
    end
  end

  always_comb begin
    case (mode_q)
      ITRNG_FIB:    sample = fib_b_q;
      ITRNG_LFSR:   sample = lfsr_data;
      ITRNG_STUCK:  sample = stuck_val;
      default:      sample = last_q;
    endcase
  end

  // Zero divider / burst length are promoted to 1 at latch time.
  assign div_eff   = (div == '0) ? DIV_W'(1) : div;
  assign burst_eff = (burst_len == '0) ? BURST_W'(1) : burst_len;

  always_ff @(posedge core_clk) begin
    if (cptra_rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= ITRNG_FIB;
      div_q       <= DIV_W'(1);
      burst_q     <= BURST_W'(1);
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
      last_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            mode_q     <= itrng_mode_e'(mode);
            div_q      <= div_eff;
            burst_q    <= burst_eff;
            wait_cnt_q <= '0;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
          if (!enable) begin
            state_q <= ST_IDLE;
          end else if (wait_cnt_q == div_q - 1'b1) begin
            burst_cnt_q <= '0;
            state_q     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          valid_q     <= 1'b1;
          data_q      <= sample;
          last_q      <= sample;
          burst_cnt_q <= burst_cnt_q + 1'b1;
          if (count_q != '1) begin
            count_q <= count_q + 1'b1;
          end
          // A burst always runs to completion; enable is only looked at here.
          if (burst_cnt_q == burst_q - 1'b1) begin
            if (enable) begin
              mode_q     <= itrng_mode_e'(mode);
              div_q      <= div_eff;
              burst_q    <= burst_eff;
              wait_cnt_q <= '0;
              state_q    <= ST_WAIT;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign itrng_data   = data_q;
  assign itrng_valid  = valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign sample_count = count_q;

endmodule

// File: tb/tb_fpga_itrng_gen.sv
// Self-checking bench for fpga_itrng_gen: schedule-level reference model with a
// per-cycle compare, plus directed scenarios pinned to hand-computed values.
module tb_fpga_itrng_gen;

  localparam int DATA_W  = 4;
  localparam int LFSR_W  = 32;
  localparam int DIV_W   = 16;
  localparam int BURST_W = 4;
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic               core_clk  = 1'b0;
  logic               cptra_rst = 1'b1;
  logic               enable    = 1'b0;
  logic [1:0]         mode      = 2'd0;
  logic [DIV_W-1:0]   div       = '0;
  logic [BURST_W-1:0] burst_len = '0;
  logic [DATA_W-1:0]  stuck_val = '0;
  logic               seed_load = 1'b0;
  logic [LFSR_W-1:0]  seed      = '0;
  logic [DATA_W-1:0]  itrng_data;
  logic               itrng_valid;
  logic               busy;
  logic [31:0]        sample_count;

  int checks = 0;
  int errors = 0;
  int lfsr_zero = 0;
  bit cmp_en = 1'b0;

  fpga_itrng_gen dut (
    .core_clk     (core_clk),
    .cptra_rst    (cptra_rst),
    .enable       (enable),
    .mode         (mode),
    .div          (div),
    .burst_len    (burst_len),
    .stuck_val    (stuck_val),
    .seed_load    (seed_load),
    .seed         (seed),
    .itrng_data   (itrng_data),
    .itrng_valid  (itrng_valid),
    .busy         (busy),
    .sample_count (sample_count)
  );

  // Clock / watchdog
  always #5 core_clk = ~core_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: generators plus an emission schedule in absolute edge numbers
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_fa, m_fb, m_last, m_hold, m_samp, m_nb;
  logic [31:0]       m_lfsr, m_count;
  logic [1:0]        m_mode;
  logic              m_valid;
  bit                m_active;
  int                m_gap, m_left;
  longint            m_n, m_emit_at;

  always @(posedge core_clk) begin
    if (cptra_rst) begin
      m_fa = 1; m_fb = 1; m_lfsr = SEED; m_last = 0; m_hold = 0;
      m_count = 0; m_valid = 0; m_active = 0; m_mode = 0; m_n = 0;
      exp_q.delete();
    end else begin
      case (m_mode)
        2'd0:    m_samp = m_fb;
        2'd1:    m_samp = m_lfsr[DATA_W-1:0];
        2'd2:    m_samp = stuck_val;
        default: m_samp = m_last;
      endcase
      m_valid = 0;
      if (!m_active) begin
        if (enable) begin
          m_active = 1; m_mode = mode;
          m_gap = (div == 0) ? 1 : int'(div);
          m_left = (burst_len == 0) ? 1 : int'(burst_len);
          m_emit_at = m_n + m_gap + 1;
        end
      end else if (m_n >= m_emit_at) begin
        m_valid = 1; m_hold = m_samp; m_last = m_samp; exp_q.push_back(m_samp);
        if (m_count != 32'hFFFF_FFFF) m_count++;
        m_left--;
        if (m_left == 0) begin
          if (enable) begin
            m_mode = mode;
            m_gap = (div == 0) ? 1 : int'(div);
            m_left = (burst_len == 0) ? 1 : int'(burst_len);
            m_emit_at = m_n + m_gap + 1;
          end else begin
            m_active = 0;
          end
        end
      end else if (!enable) begin
        m_active = 0;
      end
      if (seed_load) begin
        m_lfsr = (seed == 0) ? SEED : seed;
        m_fa = seed[DATA_W-1:0] | 4'd1; m_fb = 1;
      end else begin
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ POLY) : (m_lfsr >> 1);
        m_nb = m_fa + m_fb; m_fa = m_fb; m_fb = m_nb;
      end
      m_n++;
    end
  end

  // Scoreboard compare on the falling edge
  always @(negedge core_clk) begin
    if (cmp_en) begin
      check("valid", {31'd0, itrng_valid}, {31'd0, m_valid});
      check("busy", {31'd0, busy}, {31'd0, m_active});
      check("sample_count", sample_count, m_count);
      if (itrng_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sample: got 0x%0h expected no sample at %0t", itrng_data, $time);
        end else begin
          check("sample", {28'd0, itrng_data}, {28'd0, exp_q.pop_front()});
        end
      end else begin
        if (m_valid && exp_q.size() != 0) void'(exp_q.pop_front());
        check("hold_data", {28'd0, itrng_data}, {28'd0, m_hold});
      end
      if (dut.u_lfsr.lfsr_q == '0) lfsr_zero++;
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge core_clk);
  endtask

  task automatic do_reset();
    cptra_rst = 1'b1; enable = 1'b0; seed_load = 1'b0;
    tick(3);
    cmp_en = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output int cycles, output logic [DATA_W-1:0] d);
    cycles = budget; d = 'x;
    for (int i = 1; i <= budget; i++) begin
      @(negedge core_clk);
      if (itrng_valid) begin
        cycles = i; d = itrng_data;
        break;
      end
    end
  endtask

  task automatic capture(input int n, output logic [31:0] pat);
    pat = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge core_clk);
      pat[k] = itrng_valid;
    end
  endtask

  int c;
  logic [DATA_W-1:0] d;
  logic [31:0] pat;

  initial begin
    // 1: legacy Fibonacci timing, div=21 burst=1
    do_reset();
    check("rst_valid", {31'd0, itrng_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", sample_count, 32'd0);
    check("rst_data", {28'd0, itrng_data}, 32'd0);
    mode = 2'd0; div = 16'd21; burst_len = 4'd1; enable = 1'b1; cptra_rst = 1'b0;
    wait_valid(40, c, d);
    check("t1_first_latency", c, 32'd23);
    check("t1_first_data", {28'd0, d}, 32'h0);
    wait_valid(40, c, d);
    check("t1_period", c, 32'd22);
    check("t1_second_data", {28'd0, d}, 32'hF);
    tick(100);

    // 2: stuck-at bursts of 4 separated by 3 idle cycles
    do_reset();
    mode = 2'd2; stuck_val = 4'hA; div = 16'd3; burst_len = 4'd4; enable = 1'b1; cptra_rst = 1'b0;
    capture(15, pat);
    check("t2_pattern", pat, 32'h0000_78F0);
    check("t2_count", sample_count, 32'd8);
    check("t2_data", {28'd0, itrng_data}, 32'hA);
    tick(30);

    // 3: LFSR with zero-seed reload, then a long run
    do_reset();
    mode = 2'd1; cptra_rst = 1'b0;
    tick(7);
    seed_load = 1'b1; seed = '0; enable = 1'b1; div = 16'd2; burst_len = 4'd3;
    tick(1);
    seed_load = 1'b0;
    wait_valid(10, c, d);
    check("t3_first_latency", c, 32'd3);
    check("t3_data0", {28'd0, d}, 32'hA);
    wait_valid(10, c, d);
    check("t3_data1", {28'd0, d}, 32'hD);
    wait_valid(10, c, d);
    check("t3_data2", {28'd0, d}, 32'h5);
    tick(2000);
    seed_load = 1'b1; seed = 32'h1234_5678;
    tick(1);
    seed_load = 1'b0;
    tick(8000);
    check("t3_lfsr_nonzero", lfsr_zero, 32'd0);

    // 4: div=0 / burst_len=0 behave as 1/1
    do_reset();
    mode = 2'd0; div = '0; burst_len = '0; enable = 1'b1; cptra_rst = 1'b0;
    capture(10, pat);
    check("t4_alternate", pat, 32'h0000_0154);
    tick(50);

    // 5: enable drop mid-burst completes the burst; drop during WAIT emits nothing
    do_reset();
    mode = 2'd2; stuck_val = 4'h5; div = 16'd2; burst_len = 4'd4; enable = 1'b1; cptra_rst = 1'b0;
    wait_valid(10, c, d);
    wait_valid(10, c, d);
    enable = 1'b0;
    tick(6);
    check("t5_burst_count", sample_count, 32'd4);
    check("t5_idle_busy", {31'd0, busy}, 32'd0);
    enable = 1'b1; div = 16'd5;
    tick(1);
    check("t5_wait_busy", {31'd0, busy}, 32'd1);
    enable = 1'b0;
    tick(10);
    check("t5_no_pulse_count", sample_count, 32'd4);
    check("t5_end_busy", {31'd0, busy}, 32'd0);

    // 6: Fibonacci reseed, repeat-last mode, reset mid-EMIT
    do_reset();
    mode = 2'd0; div = 16'd2; burst_len = 4'd2; enable = 1'b1;
    seed_load = 1'b1; seed = 32'h0000_0006; cptra_rst = 1'b0;
    tick(1);
    seed_load = 1'b0;
    wait_valid(10, c, d);
    check("t6_fib0", {28'd0, d}, 32'h9);
    mode = 2'd3;
    wait_valid(10, c, d);
    check("t6_fib1_mode_not_applied", {28'd0, d}, 32'h1);
    wait_valid(10, c, d);
    check("t6_repeat_latency", c, 32'd3);
    check("t6_repeat0", {28'd0, d}, 32'h1);
    check("t6_count", sample_count, 32'd3);
    cptra_rst = 1'b1;
    tick(1);
    check("t6_rst_valid", {31'd0, itrng_valid}, 32'd0);
    check("t6_rst_count", sample_count, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    cptra_rst = 1'b0; enable = 1'b0;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpga_itrng_gen.md
Name: fpga_itrng_gen

Overview:
Parametrised pseudo-random internal-TRNG stimulus source for FPGA builds of caliptra_top. It drives the itrng_data/itrng_valid pins and replaces the fixed 4-bit Fibonacci generator with several features:
- selectable generator mode: Fibonacci, Galois LFSR, stuck-at, repeat;
- runtime rate divider and burst length;
- reseeding;
- a sample counter.

The stuck-at and repeat modes let firmware TRNG health-test paths (repetition count, adaptive proportion) be exercised on FPGA. It sits in the FPGA wrapper beside the imem/mailbox RAMs, clocked by core_clk. Its control inputs come from generic_output_wires or an AXI register slice.

Parameters:
DATA_W, 4, width of itrng_data; must match the caliptra_top itrng_data width.
LFSR_W, 32, Galois LFSR width; must be at least DATA_W.
LFSR_POLY, 32'h8020_0003, Galois feedback taps, LFSR_W bits wide.
LFSR_SEED, 32'hACE1_2468, LFSR reset value; must be non-zero.
DIV_W, 16, width of the divider input.
BURST_W, 4, width of the burst-length input.

Ports:
core_clk  in  1  clock.
cptra_rst  in  1  synchronous active-high reset.
enable  in  1  starts and keeps sample generation running.
mode  in  2  generator select: 0 Fibonacci, 1 LFSR, 2 stuck-at, 3 repeat-last.
div  in  DIV_W  idle cycles between bursts; 0 is treated as 1.
burst_len  in  BURST_W  samples per burst; 0 is treated as 1.
stuck_val  in  DATA_W  data value emitted in mode 2.
seed_load  in  1  single-cycle pulse that reseeds the generators.
seed  in  LFSR_W  reseed value.
itrng_data  out  DATA_W  sample data; held between samples.
itrng_valid  out  1  one cycle high per sample.
busy  out  1  high when the FSM is not in IDLE.
sample_count  out  32  count of emitted samples; saturates at 32'hFFFF_FFFF.

Behaviour:
- Clock and reset:
  - One clock, core_clk. Reset cptra_rst is synchronous and active-high.
  - All state is sampled only on the core_clk rising edge.
- Reset values:
  - itrng_data=0, itrng_valid=0, busy=0, sample_count=0.
  - FSM=IDLE, fib_a=fib_b=1, lfsr=LFSR_SEED, wait counter=0, burst counter=0, last_data=0.
  - Reset asserted mid-burst aborts the burst; the next cycle shows reset values.
- Generators: free-running, stepping every non-reset cycle regardless of FSM state.
  - Fibonacci: fib_b<=fib_a+fib_b (mod 2^DATA_W); fib_a<=fib_b.
  - LFSR: Galois right shift. If lsb=1, lfsr<=(lfsr>>1)^LFSR_POLY; otherwise lfsr<=lfsr>>1.
- Reseed (seed_load=1):
  - Overrides stepping for that cycle: lfsr<=seed, or LFSR_SEED if seed==0. fib_a<=seed[DATA_W-1:0]|1; fib_b<=1.
  - A sample emitted in the same cycle uses the pre-load generator value.
- Sample value by mode:
  - mode 0: fib_b.
  - mode 1: lfsr[DATA_W-1:0].
  - mode 2: stuck_val.
  - mode 3: last_data. If no sample has been emitted since reset, the value is 0.
  - last_data<=emitted value on every valid cycle.
- FSM states: IDLE, WAIT, EMIT.
  - IDLE: valid=0, busy=0. enable=1 latches mode_q, div_q=max(div,1), burst_q=max(burst_len,1); clears the wait counter; goes to WAIT.
  - WAIT: the wait counter increments.
    - enable=0: go to IDLE next cycle, no sample.
    - Wait counter reaches div_q-1: go to EMIT with burst counter=0.
    - WAIT therefore lasts exactly div_q cycles.
  - EMIT: each cycle registers itrng_valid<=1 and itrng_data<=sample; the burst counter increments.
    - After burst_q samples: if enable=1, relatch mode/div/burst and go to WAIT; otherwise go to IDLE.
    - enable falling mid-burst does not truncate the burst.
- Output timing:
  - itrng_valid is registered and is high exactly in the cycles after the EMIT cycles, i.e. 1 cycle of latency.
  - In steady state, period = div_q + burst_q cycles.
  - The legacy wrapper generator is matched by mode=0, div=21, burst_len=1 (period 22).
- Configuration changes to mode, div, burst_len take effect only at the next relatch; they never take effect mid-WAIT or mid-EMIT.
- sample_count increments on each itrng_valid cycle and holds at all-ones.

Decomposition:
- Package fpga_itrng_pkg holds:
  - mode enum itrng_mode_e (ITRNG_FIB, ITRNG_LFSR, ITRNG_STUCK, ITRNG_REPEAT);
  - FSM enum itrng_state_e;
  - default LFSR_POLY and LFSR_SEED constants.
- One sub-module, fpga_itrng_lfsr, contains the Galois LFSR with its load/step logic. It is reusable for other FPGA stimulus blocks.

Test Plan:
1. Reset, then enable=1, mode=0, div=21, burst_len=1 -> first itrng_valid pulse 23 cycles after reset release; pulses 22 cycles apart; data equals a bit-accurate Fibonacci model stepped from reset.
2. mode=2, stuck_val=4'hA, div=3, burst_len=4 -> pattern of 4 consecutive valid cycles, each with data 0xA, then 3 idle cycles, repeating; sample_count=8 after two bursts.
3. mode=1; seed_load pulse with seed=0 -> lfsr reloads LFSR_SEED; emitted data matches the LFSR model; lfsr is never zero over 10k cycles.
4. div=0, burst_len=0 -> treated as 1/1: valid alternates high/low every cycle.
5. enable dropped on the 2nd of 4 burst samples -> burst completes with 4 pulses, then busy=0. Enable dropped during WAIT -> no further pulse.
6. mode=3 after one Fibonacci burst -> all following samples equal the last Fibonacci value. cptra_rst pulsed mid-EMIT -> valid=0 and sample_count=0 on the next cycle.
